dec_text_writer: RTL and testbench
==================================

Name: dec_text_writer

Overview:
- Downstream consumer of the 16-bit-to-ASCII decimal converter. Takes its five ASCII digit bytes (ten-thousands to units).
- Detects when the digits change, or when a rewrite is forced.
- Snapshots the digits, applies optional leading-zero blanking, and writes the 5-character field into the screen text buffer, one character per transfer, over a valid/ready write port.
- Lets the display show a live numeric readout without the text buffer being written every cycle.

Parameters:
- ADDR_W, 6, text-buffer address width in bits.
- BASE_ADDR, 0, buffer address of the leftmost character of the field.
- LEAD_BLANK, 1, 1 = replace leading "0" characters with FILL_CHAR; 0 = write the digits unchanged.
- FILL_CHAR, 8'h20, replacement character for blanked leading zeros.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- ten_thousands  in  8  ASCII digit 4 (MSD).
- thousands  in  8  ASCII digit 3.
- hundreds  in  8  ASCII digit 2.
- tens  in  8  ASCII digit 1.
- units  in  8  ASCII digit 0 (LSD).
- force_i  in  1  single-cycle request to rewrite the field even if the digits are unchanged.
- wr_valid_o  out  1  write request to the text buffer.
- wr_ready_i  in  1  text buffer accepts the write.
- wr_addr_o  out  ADDR_W  write address.
- wr_data_o  out  8  character to write.
- busy_o  out  1  high in LOAD, WRITE and DONE.
- done_o  out  1  one-cycle pulse after the 5th character is accepted.

Behaviour:
- Reset values (rst_i high at an edge): state IDLE; snap[4:0] = 8'h00 each; field regs = 8'h00; idx = 0; pending = 0; wr_valid_o = 0; wr_addr_o = BASE_ADDR; wr_data_o = 0; busy_o = 0; done_o = 0.
  - Because snap resets to 8'h00, the first IDLE cycle after reset always sees a difference and paints the field.
- All outputs are registered.
- IDLE:
  - Trigger = force_i OR pending OR ({ten_thousands..units} != snap).
  - On trigger: snap <= inputs; pending <= 0; go to LOAD.
- LOAD (1 cycle): build field from snap.
  - field[0] (ten_thousands) through field[3] (tens): position i becomes FILL_CHAR when LEAD_BLANK=1 and snap positions 0..i are all "0" (8'h30).
  - field[4] (units) is never blanked.
  - Any other byte, digit or not, passes through unchanged and ends blanking.
  - idx <= 0; go to WRITE.
- WRITE:
  - wr_valid_o = 1; wr_addr_o = (BASE_ADDR + idx) mod 2^ADDR_W; wr_data_o = field[idx].
  - A transfer occurs on an edge where wr_valid_o and wr_ready_i are both high.
  - While not accepted, wr_valid_o, wr_addr_o and wr_data_o hold stable. wr_valid_o never drops before its transfer.
  - On a transfer with idx < 4: idx+1, and the next character is presented in the following cycle (back-to-back transfers allowed).
  - On a transfer with idx == 4: wr_valid_o <= 0; go to DONE.
- DONE (1 cycle): done_o = 1; go to IDLE.
- Latency with wr_ready_i held high:
  - Trigger seen in IDLE at cycle T; LOAD at T+1.
  - Writes at T+2 through T+6.
  - done_o at T+7; IDLE again at T+8.
- Digit changes during LOAD/WRITE/DONE:
  - Ignored for the burst in progress, which writes the snapshot.
  - The mismatch against snap is detected on return to IDLE, giving a new burst. Intermediate values may be skipped; only the latest value is written.
- force_i while busy sets pending, which is serviced on return to IDLE. force_i together with a digit change in IDLE gives exactly one burst.
- Reset mid-burst: wr_valid_o low after that edge. Characters already written stay in the buffer. The next IDLE cycle repaints.
- Width rules: idx is 3 bits. The address sum is truncated to ADDR_W bits (wraps).

Test Plan:
- Reset with inputs "00000", wr_ready_i=1, LEAD_BLANK=1 -> addresses 0..4, data "    0" (20,20,20,20,30) on cycles T+2..T+6; done_o at T+7; no further writes while inputs hold.
- Inputs change "00000" -> "01234" -> one burst of " 1234"; "10005" -> "10005" (inner zeros kept); "00700" -> "  700".
- wr_ready_i low for 3 cycles while idx=2 -> wr_addr_o=2 and wr_data_o held and wr_valid_o stays 1; the burst resumes and completes with done_o one cycle after the 5th accept.
- Digits change "00042" -> "00043" mid-burst -> first burst writes "   42" in full, then a second burst writes "   43"; LEAD_BLANK=0 variant writes "00042" then "00043".
- force_i pulse with unchanged inputs "00100" in IDLE -> one rewrite "  100"; force_i pulse during a burst -> exactly one extra burst afterwards.
- BASE_ADDR=62, ADDR_W=6 -> addresses 62,63,0,1,2. rst_i asserted at idx=3 -> wr_valid_o=0 next cycle, then a full repaint from idx 0.

Source files
------------

// File: rtl/dec_text_writer.sv
// dec_text_writer
//   Copies the five ASCII digits of a decimal readout into a screen text
//   buffer. The field is rewritten only when the digits differ from the last
//   painted snapshot or a rewrite is requested. Each rewrite writes five
//   characters, one per valid/ready transfer. Leading zeros can be blanked.
//
// Ports
//   clk            system clock, rising edge
//   rst_i          synchronous active-high reset
//   ten_thousands  ASCII digit 4 (most significant)
//   thousands      ASCII digit 3
//   hundreds       ASCII digit 2
//   tens           ASCII digit 1
//   units          ASCII digit 0 (least significant)
//   force_i        single-cycle request to rewrite the field
//   wr_valid_o     write request to the text buffer
//   wr_ready_i     text buffer accepts the write
//   wr_addr_o      write address
//   wr_data_o      character to write
//   busy_o         high while a rewrite is in progress (LOAD, WRITE, DONE)
//   done_o         one-cycle pulse after the fifth character is accepted
module dec_text_writer #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned BASE_ADDR  = 0,
    parameter bit          LEAD_BLANK = 1'b1,
    parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic [7:0]        ten_thousands,
    input  logic [7:0]        thousands,
    input  logic [7:0]        hundreds,
    input  logic [7:0]        tens,
    input  logic [7:0]        units,
    input  logic              force_i,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [7:0]        ASCII_ZERO = 8'h30;

    state_t            state_q, state_d;
    logic [7:0]        digits      [5];
    logic [7:0]        snap_q      [5];
    logic [7:0]        snap_d      [5];
    logic [7:0]        field_q     [5];
    logic [7:0]        field_d     [5];
    logic [7:0]        field_build [5];
    logic [2:0]        idx_q, idx_d, idx_inc;
    logic              pending_q, pending_d;
    logic              wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [7:0]        wr_data_d;
    logic              busy_d, done_d;
    logic              differs;
    logic              blank_run;
    logic              xfer;

    // Position 0 is the leftmost (most significant) character.
    always_comb begin
        digits[0] = ten_thousands;
        digits[1] = thousands;
        digits[2] = hundreds;
        digits[3] = tens;
        digits[4] = units;
    end

    always_comb begin
        differs = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (digits[i] != snap_q[i]) differs = 1'b1;
        end
    end

    // Blanking runs left to right and stops at the first non-"0" byte; the
    // units character is always shown so a zero reading is never empty.
    // NOTE: blank_run is updated in sequence within one evaluation, so blocking
    // assignments are required here; clocked state below uses non-blocking.
    always_comb begin
        blank_run = LEAD_BLANK;
        for (int i = 0; i < 4; i++) begin
            blank_run      = blank_run && (snap_q[i] == ASCII_ZERO);
            field_build[i] = blank_run ? FILL_CHAR : snap_q[i];
        end
        field_build[4] = snap_q[4];
    end

    // Next-state and next-output logic.
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        field_d    = field_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        wr_valid_d = wr_valid_o;
        wr_addr_d  = wr_addr_o;
        wr_data_d  = wr_data_o;
        done_d     = 1'b0;
        idx_inc    = idx_q + 3'd1;
        xfer       = wr_valid_o && wr_ready_i;

        case (state_q)
            S_IDLE: begin
                if (force_i || pending_q || differs) begin
                    snap_d    = digits;
                    pending_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                field_d    = field_build;
                idx_d      = 3'd0;
                wr_valid_d = 1'b1;
                wr_addr_d  = BASE;
                wr_data_d  = field_build[0];
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                if (xfer) begin
                    if (idx_q == 3'd4) begin
                        wr_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        idx_d     = idx_inc;
                        wr_addr_d = BASE + ADDR_W'(idx_inc);
                        wr_data_d = field_q[idx_inc];
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A request that arrives mid-rewrite is remembered for the next IDLE.
        if (state_q != S_IDLE && force_i) pending_d = 1'b1;

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: the snapshot and field registers are reset deliberately; an
    // all-zero snapshot never matches ASCII digits, so the field is repainted
    // right after reset.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < 5; i++) begin
                snap_q[i]  <= 8'h00;
                field_q[i] <= 8'h00;
            end
            idx_q      <= 3'd0;
            pending_q  <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_addr_o  <= BASE;
            wr_data_o  <= 8'h00;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            snap_q     <= snap_d;
            field_q    <= field_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            wr_valid_o <= wr_valid_d;
            wr_addr_o  <= wr_addr_d;
            wr_data_o  <= wr_data_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
        end
    end

endmodule

// File: tb/tb_dec_text_writer.sv
// Testbench for dec_text_writer. Three instances share the inputs:
//   u0: default (BASE 0, leading blanking), u1: no blanking, u2: BASE 62.
module tb_dec_text_writer;

    localparam int AW = 6;

    typedef struct {
        int a;
        int d;
        int c;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [7:0]    dig [5];
    logic          force_req;
    logic          wr_ready;
    logic          wv [3];
    logic [AW-1:0] wa [3];
    logic [7:0]    wd [3];
    logic          bz [3];
    logic          dn [3];

    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    rec_t          wq [3][$];
    int            dq [3][$];
    rec_t          exq [$];
    logic [39:0]   vals [$];
    logic [39:0]   cur;
    logic [7:0]    tbuf [3][64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dec_text_writer #(.ADDR_W(AW), .BASE_ADDR(0), .LEAD_BLANK(1'b1), .FILL_CHAR(8'h20)) u0 (
        .clk(clk), .rst_i(rst_i), .ten_thousands(dig[0]), .thousands(dig[1]),
        .hundreds(dig[2]), .tens(dig[3]), .units(dig[4]), .force_i(force_req),
        .wr_valid_o(wv[0]), .wr_ready_i(wr_ready), .wr_addr_o(wa[0]), .wr_data_o(wd[0]),
        .busy_o(bz[0]), .done_o(dn[0]));

    dec_text_writer #(.ADDR_W(AW), .BASE_ADDR(0), .LEAD_BLANK(1'b0), .FILL_CHAR(8'h20)) u1 (
        .clk(clk), .rst_i(rst_i), .ten_thousands(dig[0]), .thousands(dig[1]),
        .hundreds(dig[2]), .tens(dig[3]), .units(dig[4]), .force_i(force_req),
        .wr_valid_o(wv[1]), .wr_ready_i(wr_ready), .wr_addr_o(wa[1]), .wr_data_o(wd[1]),
        .busy_o(bz[1]), .done_o(dn[1]));

    dec_text_writer #(.ADDR_W(AW), .BASE_ADDR(62), .LEAD_BLANK(1'b1), .FILL_CHAR(8'h20)) u2 (
        .clk(clk), .rst_i(rst_i), .ten_thousands(dig[0]), .thousands(dig[1]),
        .hundreds(dig[2]), .tens(dig[3]), .units(dig[4]), .force_i(force_req),
        .wr_valid_o(wv[2]), .wr_ready_i(wr_ready), .wr_addr_o(wa[2]), .wr_data_o(wd[2]),
        .busy_o(bz[2]), .done_o(dn[2]));

    // Transfer monitor: a write is accepted at the edge closing a cycle in
    // which valid and ready are both high (and reset is not asserted).
    always @(negedge clk) begin
        if (!rst_i) begin
            for (int u = 0; u < 3; u++) begin
                if (wv[u] && wr_ready) begin
                    wq[u].push_back('{int'(wa[u]), int'(wd[u]), cyc});
                    tbuf[u][wa[u]] <= wd[u];
                end
                if (dn[u]) dq[u].push_back(cyc);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int base_of(input int u);
        return (u == 2) ? 62 : 0;
    endfunction

    // Characters left of the first significant position among the top four
    // become spaces; everything from there on is shown as is.
    function automatic logic [39:0] model_field(input logic [39:0] dg, input bit lb);
        logic [39:0] f;
        int          first_kept;
        f = dg;
        first_kept = 4;
        for (int i = 3; i >= 0; i--)
            if (dg[8*i +: 8] != 8'h30) first_kept = i;
        if (lb)
            for (int i = 0; i < first_kept; i++) f[8*i +: 8] = 8'h20;
        return f;
    endfunction

    function automatic logic [39:0] pack_str(input string s);
        logic [39:0] r;
        for (int i = 0; i < 5; i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    task automatic fill_expected(input int u);
        logic [39:0] f;
        exq.delete();
        foreach (vals[b]) begin
            f = model_field(vals[b], u != 1);
            for (int i = 0; i < 5; i++)
                exq.push_back('{(base_of(u) + i) % 64, int'(f[8*i +: 8]), 0});
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_digits(input logic [39:0] v);
        cur = v;
        for (int i = 0; i < 5; i++) dig[i] = v[8*i +: 8];
    endtask

    task automatic clear_logs();
        for (int u = 0; u < 3; u++) begin
            wq[u].delete();
            dq[u].delete();
        end
    endtask

    function automatic logic [39:0] rand_digits();
        logic [39:0] r;
        int          p;
        for (int i = 0; i < 5; i++) begin
            p = $urandom_range(0, 99);
            if (p < 40)      r[8*i +: 8] = 8'h30;
            else if (p < 95) r[8*i +: 8] = 8'(8'h30 + $urandom_range(0, 9));
            else             r[8*i +: 8] = 8'($urandom_range(0, 255));
        end
        return r;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int t0;
        rst_i = 1'b1;
        wr_ready = 1'b1;
        force_req = 1'b0;
        set_digits(pack_str("00000"));
        step(2);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            n_checks++;
            if (wv[u] !== 1'b0 || bz[u] !== 1'b0 || dn[u] !== 1'b0 ||
                wa[u] !== AW'(base_of(u)) || wd[u] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset u%0d: got valid %b busy %b done %b addr %0d data %02h, want 0 0 0 %0d 00",
                         u, wv[u], bz[u], dn[u], wa[u], wd[u], base_of(u));
            end
        end
        clear_logs();
        step(1);
        rst_i = 1'b0;
        t0 = cyc;
        step(14);
        vals.delete();
        vals.push_back(pack_str("00000"));
        for (int u = 0; u < 3; u++) begin
            fill_expected(u);
            n_checks++;
            if (wq[u].size() != exq.size()) begin
                n_fail++;
                $display("FAIL reset_paint u%0d count: got %0d, want %0d", u, wq[u].size(), exq.size());
            end else begin
                for (int i = 0; i < exq.size(); i++) begin
                    n_checks++;
                    if (wq[u][i].a != exq[i].a || wq[u][i].d != exq[i].d || wq[u][i].c != t0 + 2 + i) begin
                        n_fail++;
                        $display("FAIL reset_paint u%0d w%0d: got addr %0d data %02h cyc %0d, want %0d %02h %0d",
                                 u, i, wq[u][i].a, wq[u][i].d, wq[u][i].c, exq[i].a, exq[i].d, t0 + 2 + i);
                    end
                end
            end
        end
        n_checks++;
        if (dq[0].size() != 1 || (dq[0].size() == 1 && dq[0][0] != t0 + 7)) begin
            n_fail++;
            $display("FAIL reset_done: got %0d pulses (first at %0d), want 1 at %0d",
                     dq[0].size(), (dq[0].size() > 0) ? dq[0][0] : -1, t0 + 7);
        end
    endtask

    task automatic test_patterns();
        string pats [3] = '{"01234", "10005", "00700"};
        for (int p = 0; p < 3; p++) begin
            clear_logs();
            set_digits(pack_str(pats[p]));
            step(12);
            vals.delete();
            vals.push_back(cur);
            for (int u = 0; u < 3; u++) begin
                fill_expected(u);
                n_checks++;
                if (wq[u].size() != exq.size()) begin
                    n_fail++;
                    $display("FAIL pattern %s u%0d count: got %0d, want %0d", pats[p], u, wq[u].size(), exq.size());
                end else begin
                    for (int i = 0; i < exq.size(); i++) begin
                        n_checks++;
                        if (wq[u][i].a != exq[i].a || wq[u][i].d != exq[i].d) begin
                            n_fail++;
                            $display("FAIL pattern %s u%0d w%0d: got addr %0d data %02h, want %0d %02h",
                                     pats[p], u, i, wq[u][i].a, wq[u][i].d, exq[i].a, exq[i].d);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int t0;
        int exp_c [5];
        clear_logs();
        set_digits(pack_str("98765"));
        t0 = cyc;
        exp_c = '{t0 + 2, t0 + 3, t0 + 7, t0 + 8, t0 + 9};
        step(4);
        wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (wv[0] !== 1'b1 || wa[0] !== AW'(2) || wd[0] !== 8'h37) begin
                n_fail++;
                $display("FAIL stall hold %0d: got valid %b addr %0d data %02h, want 1 2 37", k, wv[0], wa[0], wd[0]);
            end
            step(1);
        end
        wr_ready = 1'b1;
        step(10);
        n_checks++;
        if (wq[0].size() != 5) begin
            n_fail++;
            $display("FAIL stall count: got %0d, want 5", wq[0].size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (wq[0][i].c != exp_c[i] || wq[0][i].a != i || wq[0][i].d != int'(cur[8*i +: 8])) begin
                    n_fail++;
                    $display("FAIL stall w%0d: got cyc %0d addr %0d data %02h, want %0d %0d %02h",
                             i, wq[0][i].c, wq[0][i].a, wq[0][i].d, exp_c[i], i, cur[8*i +: 8]);
                end
            end
        end
        n_checks++;
        if (dq[0].size() != 1 || (dq[0].size() == 1 && dq[0][0] != t0 + 10)) begin
            n_fail++;
            $display("FAIL stall done: got %0d pulses, want 1 at %0d", dq[0].size(), t0 + 10);
        end
    endtask

    // Shared body for the scenarios that expect a list of whole rewrites.
    task automatic test_bursts(input string name, input int steps_before, input logic [39:0] v_a,
                               input bit do_change, input logic [39:0] v_b, input bit frc_a, input bit frc_mid);
        clear_logs();
        set_digits(v_a);
        force_req = frc_a;
        step(1);
        force_req = 1'b0;
        step(steps_before);
        if (do_change) set_digits(v_b);
        force_req = frc_mid;
        step(1);
        force_req = 1'b0;
        step(22);
        vals.delete();
        vals.push_back(v_a);
        if (do_change || frc_mid) vals.push_back(cur);
        for (int u = 0; u < 3; u++) begin
            fill_expected(u);
            n_checks++;
            if (wq[u].size() != exq.size() || dq[u].size() != vals.size()) begin
                n_fail++;
                $display("FAIL %s u%0d counts: got %0d writes %0d done, want %0d %0d",
                         name, u, wq[u].size(), dq[u].size(), exq.size(), vals.size());
            end else begin
                for (int i = 0; i < exq.size(); i++) begin
                    n_checks++;
                    if (wq[u][i].a != exq[i].a || wq[u][i].d != exq[i].d) begin
                        n_fail++;
                        $display("FAIL %s u%0d w%0d: got addr %0d data %02h, want %0d %02h",
                                 name, u, i, wq[u][i].a, wq[u][i].d, exq[i].a, exq[i].d);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_burst_change();
        test_bursts("mid_change", 2, pack_str("00042"), 1'b1, pack_str("00043"), 1'b0, 1'b0);
    endtask

    task automatic test_force();
        set_digits(pack_str("00100"));
        step(14);
        // Unchanged digits, force in IDLE: one rewrite.
        test_bursts("force_idle", 12, pack_str("00100"), 1'b0, 40'h0, 1'b1, 1'b0);
        // Force again while busy: exactly one extra rewrite.
        test_bursts("force_busy", 2, pack_str("00100"), 1'b0, 40'h0, 1'b1, 1'b1);
        // Force together with a digit change: still one rewrite.
        test_bursts("force_change", 12, pack_str("00101"), 1'b0, 40'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        int t0;
        clear_logs();
        set_digits(pack_str("12345"));
        t0 = cyc;
        step(5);
        rst_i = 1'b1;
        step(1);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            n_checks++;
            if (wv[u] !== 1'b0 || bz[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset u%0d: got valid %b busy %b, want 0 0", u, wv[u], bz[u]);
            end
        end
        rst_i = 1'b0;
        step(14);
        vals.delete();
        vals.push_back(cur);
        for (int u = 0; u < 3; u++) begin
            fill_expected(u);
            n_checks++;
            if (wq[u].size() != 8) begin
                n_fail++;
                $display("FAIL midreset u%0d count: got %0d, want 8", u, wq[u].size());
            end else begin
                for (int i = 0; i < 5; i++) begin
                    n_checks++;
                    if (wq[u][3+i].a != exq[i].a || wq[u][3+i].d != exq[i].d || wq[u][3+i].c != t0 + 8 + i) begin
                        n_fail++;
                        $display("FAIL midreset u%0d repaint w%0d: got addr %0d data %02h cyc %0d, want %0d %02h %0d",
                                 u, i, wq[u][3+i].a, wq[u][3+i].d, wq[u][3+i].c, exq[i].a, exq[i].d, t0 + 8 + i);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [39:0] f;
        int          n;
        for (int it = 0; it < 25; it++) begin
            set_digits(rand_digits());
            n = $urandom_range(0, 12);
            for (int k = 0; k < n; k++) begin
                wr_ready  = ($urandom_range(0, 3) != 0);
                force_req = ($urandom_range(0, 15) == 0);
                if (k == n / 2 && $urandom_range(0, 1) == 1) set_digits(rand_digits());
                step(1);
            end
            wr_ready  = 1'b1;
            force_req = 1'b0;
            step(25);
            for (int u = 0; u < 3; u++) begin
                f = model_field(cur, u != 1);
                for (int i = 0; i < 5; i++) begin
                    n_checks++;
                    if (tbuf[u][(base_of(u) + i) % 64] !== f[8*i +: 8]) begin
                        n_fail++;
                        $display("FAIL random it%0d u%0d pos%0d: got %02h, want %02h",
                                 it, u, i, tbuf[u][(base_of(u) + i) % 64], f[8*i +: 8]);
                    end
                end
                n_checks++;
                if (bz[u] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random it%0d u%0d idle: got busy %b, want 0", it, u, bz[u]);
                end
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++)
            for (int a = 0; a < 64; a++) tbuf[u][a] = 8'h00;
        test_reset();
        test_patterns();
        test_backpressure();
        test_mid_burst_change();
        test_force();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
